// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
//   Shared types and defaults for the I2S transmit path.
//   - i2s_state_t : serialiser FSM states (IDLE, START, RUN, DRAIN)
//   - *_DEF       : default geometry (24-bit samples, 32-bit slots, BCLK half
//                   period of 8 CLOCK_50 cycles -> BCLK 3.125 MHz, fs 48.828 kHz)
//   - frame_bits  : BCLK periods per stereo frame
// -----------------------------------------------------------------------------
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } i2s_state_t;

  localparam int SAMPLE_W_DEF  = 24;
  localparam int SLOT_W_DEF    = 32;
  localparam int BCLK_HALF_DEF = 8;

  function automatic int frame_bits(input int slot_w);
    return 2 * slot_w;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// -----------------------------------------------------------------------------
// i2s_clkgen
//   Bit-clock / word-select generator for audio_i2s_tx.
//   Divides CLOCK_50 by 2*BCLK_HALF into aud_bclk, counts bit positions within
//   the stereo frame on BCLK falling edges and drives aud_lrck from them.
//   Optional macro I2S_MCLK_EN adds aud_mclk = 4 x BCLK.
// Ports:
//   CLOCK_50, reset_reg_n : clock, asynchronous active-low reset
//   active                : serialiser not IDLE (divider runs)
//   start                 : START cycle, re-arms divider and bit counter
//   drain                 : DRAIN state, last fall event keeps aud_lrck high
//   aud_bclk, aud_lrck    : I2S bit clock and word select (0 = left)
//   fall_evt              : combinational strobe, BCLK falls on the next edge
//   bit_nxt               : bit position that the fall event moves to
//   aud_mclk              : (I2S_MCLK_EN only) master clock, 0 while idle
// -----------------------------------------------------------------------------
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int SLOT_W    = SLOT_W_DEF,
  parameter int BCLK_HALF = BCLK_HALF_DEF,
  parameter int BIT_W     = $clog2(frame_bits(SLOT_W))
) (
  input  logic             CLOCK_50,
  input  logic             reset_reg_n,
  input  logic             active,
  input  logic             start,
  input  logic             drain,
  output logic             aud_bclk,
  output logic             aud_lrck,
  output logic             fall_evt,
  output logic [BIT_W-1:0] bit_nxt
`ifdef I2S_MCLK_EN
  ,
  output logic             aud_mclk
`endif
);

  localparam int               DIV_W    = $clog2(BCLK_HALF);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(frame_bits(SLOT_W) - 1);
  localparam logic [BIT_W-1:0] SLOT_IDX = BIT_W'(SLOT_W);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bclk_q, bclk_d;
  logic             lrck_q, lrck_d;

  always_comb begin
    // NOTE: every signal written here is given a default first, so no branch
    // can leave one unassigned and infer a latch.
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    bclk_d    = bclk_q;
    lrck_d    = lrck_q;
    fall_evt  = 1'b0;
    bit_nxt   = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);

    if (!active) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
      lrck_d    = 1'b1;
    end else if (start) begin
      // Parking the counter on the last bit makes the first fall a frame load.
      div_cnt_d = '0;
      bclk_d    = 1'b0;
      lrck_d    = 1'b1;
      bit_cnt_d = BIT_LAST;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
      if (bclk_q) begin
        fall_evt  = 1'b1;
        bit_cnt_d = bit_nxt;
        // The final fall of a drain returns to IDLE, where word select rests high.
        if (bit_nxt == '0)            lrck_d = drain;
        else if (bit_nxt == SLOT_IDX) lrck_d = 1'b1;
      end
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge CLOCK_50 or negedge reset_reg_n) begin
    if (!reset_reg_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bclk_q    <= 1'b0;
      lrck_q    <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrck_q    <= lrck_d;
    end
  end

  assign aud_bclk = bclk_q;
  assign aud_lrck = lrck_q;

`ifdef I2S_MCLK_EN
  localparam int                MCLK_HALF = BCLK_HALF / 4;
  localparam int                MCLK_W    = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam logic [MCLK_W-1:0] MCLK_LAST = MCLK_W'(MCLK_HALF - 1);

  if ((BCLK_HALF % 4) != 0 || BCLK_HALF < 4) begin : g_mclk_chk
    $error("i2s_clkgen: BCLK_HALF must be a multiple of 4 when I2S_MCLK_EN is set");
  end

  logic [MCLK_W-1:0] mclk_cnt_q, mclk_cnt_d;
  logic              mclk_q, mclk_d;

  // Restarted together with the BCLK divider so MCLK edges stay BCLK-aligned.
  always_comb begin
    mclk_cnt_d = mclk_cnt_q + MCLK_W'(1);
    mclk_d     = mclk_q;
    if (!active || start) begin
      mclk_cnt_d = '0;
      mclk_d     = 1'b0;
    end else if (mclk_cnt_q == MCLK_LAST) begin
      mclk_cnt_d = '0;
      mclk_d     = ~mclk_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_reg_n) begin
    if (!reset_reg_n) begin
      mclk_cnt_q <= '0;
      mclk_q     <= 1'b0;
    end else begin
      mclk_cnt_q <= mclk_cnt_d;
      mclk_q     <= mclk_d;
    end
  end

  assign aud_mclk = mclk_q;
`endif

endmodule

// File: rtl/audio_i2s_tx.sv
// -----------------------------------------------------------------------------
// audio_i2s_tx
//   Philips-format I2S transmitter fed by the synthesiser's stereo output.
//   One stereo sample per sample_valid strobe lands in a holding buffer, is
//   copied into the shift registers at the next frame boundary and sent left
//   then right, MSB first, one BCLK after the LRCK edge. An empty buffer at a
//   frame boundary repeats the previous sample (underrun); a second strobe
//   before the boundary replaces the buffered sample (overrun).
//   Optional macro I2S_MCLK_EN adds the aud_mclk output (4 x BCLK).
// Ports:
//   CLOCK_50, reset_reg_n  : clock, asynchronous active-low reset
//   enable                 : run; when dropped the current frame completes
//   lsample, rsample       : two's-complement samples, SAMPLE_W bits
//   sample_valid           : one-cycle strobe (engine's cycle-complete pulse)
//   sample_ready           : holding buffer empty
//   aud_bclk/lrck/dacdat   : I2S bit clock, word select (0 = left), data
//   underrun, overrun      : one-cycle rate-mismatch pulses
//   frame_start            : one-cycle pulse per frame load
//   aud_mclk               : (I2S_MCLK_EN only) codec master clock
// -----------------------------------------------------------------------------
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int SLOT_W    = SLOT_W_DEF,
  parameter int BCLK_HALF = BCLK_HALF_DEF
) (
  input  logic                CLOCK_50,
  input  logic                reset_reg_n,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] lsample,
  input  logic [SAMPLE_W-1:0] rsample,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                aud_bclk,
  output logic                aud_lrck,
  output logic                aud_dacdat,
  output logic                underrun,
  output logic                overrun,
  output logic                frame_start
`ifdef I2S_MCLK_EN
  ,
  output logic                aud_mclk
`endif
);

  localparam int               BIT_W    = $clog2(frame_bits(SLOT_W));
  localparam logic [BIT_W-1:0] SLOT_IDX = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] SW_IDX   = BIT_W'(SAMPLE_W);

  if (SAMPLE_W < 16 || SAMPLE_W >= SLOT_W || BCLK_HALF < 2) begin : g_param_chk
    $error("audio_i2s_tx: illegal SAMPLE_W/SLOT_W/BCLK_HALF combination");
  end

  i2s_state_t state_q, state_d;

  logic                full_q, full_d;
  logic [SAMPLE_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [SAMPLE_W-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
  logic [SAMPLE_W-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic [SAMPLE_W-1:0] new_l, new_r;
  logic                dacdat_q, dacdat_d;
  logic                underrun_q, underrun_d;
  logic                overrun_q, overrun_d;
  logic                frame_start_q, frame_start_d;

  logic             fall_evt, wrap_evt, load, right;
  logic [BIT_W-1:0] bit_nxt, pos;

  i2s_clkgen #(
    .SLOT_W   (SLOT_W),
    .BCLK_HALF(BCLK_HALF),
    .BIT_W    (BIT_W)
  ) u_clkgen (
    .CLOCK_50   (CLOCK_50),
    .reset_reg_n(reset_reg_n),
    .active     (state_q != IDLE),
    .start      (state_q == START),
    .drain      (state_q == DRAIN),
    .aud_bclk   (aud_bclk),
    .aud_lrck   (aud_lrck),
    .fall_evt   (fall_evt),
    .bit_nxt    (bit_nxt)
`ifdef I2S_MCLK_EN
    ,
    .aud_mclk   (aud_mclk)
`endif
  );

  assign wrap_evt = fall_evt && (bit_nxt == '0);
  assign load     = wrap_evt && (state_q == RUN);
  assign right    = (bit_nxt >= SLOT_IDX);
  assign pos      = right ? bit_nxt - SLOT_IDX : bit_nxt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = START;
      START:   state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN:   if (wrap_evt) state_d = IDLE;
               else if (enable) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    full_d        = full_q;
    buf_l_d       = buf_l_q;
    buf_r_d       = buf_r_q;
    last_l_d      = last_l_q;
    last_r_d      = last_r_q;
    shift_l_d     = shift_l_q;
    shift_r_d     = shift_r_q;
    dacdat_d      = dacdat_q;
    underrun_d    = 1'b0;
    overrun_d     = 1'b0;
    frame_start_d = 1'b0;

    // Frame source: buffered sample, else a strobe arriving this very cycle,
    // else a repeat of the previous frame.
    new_l = full_q ? buf_l_q : (sample_valid ? lsample : last_l_q);
    new_r = full_q ? buf_r_q : (sample_valid ? rsample : last_r_q);

    if (load) begin
      shift_l_d     = new_l;
      shift_r_d     = new_r;
      last_l_d      = new_l;
      last_r_d      = new_r;
      full_d        = 1'b0;
      frame_start_d = 1'b1;
      underrun_d    = !full_q && !sample_valid;
      dacdat_d      = 1'b0;
    end else if (fall_evt) begin
      // Slot position 0 is the Philips one-bit delay; bits past SAMPLE_W pad with 0.
      dacdat_d = 1'b0;
      if (!wrap_evt && pos != '0 && pos <= SW_IDX) begin
        if (right) begin
          dacdat_d  = shift_r_q[SAMPLE_W-1];
          shift_r_d = {shift_r_q[SAMPLE_W-2:0], 1'b0};
        end else begin
          dacdat_d  = shift_l_q[SAMPLE_W-1];
          shift_l_d = {shift_l_q[SAMPLE_W-2:0], 1'b0};
        end
      end
    end

    // A strobe on a load with an empty buffer already went straight into the frame.
    if (sample_valid && !(load && !full_q)) begin
      buf_l_d   = lsample;
      buf_r_d   = rsample;
      full_d    = 1'b1;
      overrun_d = full_q && !load;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_reg_n) begin
    if (!reset_reg_n) begin
      // NOTE: sample storage is reset too, so a post-reset underrun replays
      // silence rather than stale audio.
      state_q       <= IDLE;
      full_q        <= 1'b0;
      buf_l_q       <= '0;
      buf_r_q       <= '0;
      last_l_q      <= '0;
      last_r_q      <= '0;
      shift_l_q     <= '0;
      shift_r_q     <= '0;
      dacdat_q      <= 1'b0;
      underrun_q    <= 1'b0;
      overrun_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      full_q        <= full_d;
      buf_l_q       <= buf_l_d;
      buf_r_q       <= buf_r_d;
      last_l_q      <= last_l_d;
      last_r_q      <= last_r_d;
      shift_l_q     <= shift_l_d;
      shift_r_q     <= shift_r_d;
      dacdat_q      <= dacdat_d;
      underrun_q    <= underrun_d;
      overrun_q     <= overrun_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign sample_ready = ~full_q;
  assign aud_dacdat   = dacdat_q;
  assign underrun     = underrun_q;
  assign overrun      = overrun_q;
  assign frame_start  = frame_start_q;

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Downstream consumer of the synthesizer's stereo output (lsound_out/rsound_out, xxxx_zero cycle-complete strobe).
- Accepts one stereo sample per strobe into a holding buffer and generates BCLK/LRCK from CLOCK_50.
- Serialises left then right, MSB-first, in Philips I2S format to the codec DAC pin.
- Flags underrun and overrun so software or the status LEDs can detect engine/codec rate mismatch.

Parameters:
- SAMPLE_W, 24: bits per channel sample; legal range 16..SLOT_W-1.
- SLOT_W, 32: BCLK periods per channel slot; frame = 2*SLOT_W BCLKs.
- BCLK_HALF, 8: CLOCK_50 cycles per BCLK half-period, minimum 2. Defaults give BCLK = 3.125 MHz and fs = 48.828 kHz.

Ports:
- CLOCK_50  in  1  system clock.
- reset_reg_n  in  1  asynchronous active-low reset.
- enable  in  1  run serialiser; when low, output stops after the current frame.
- lsample  in  SAMPLE_W  left sample, two's complement.
- rsample  in  SAMPLE_W  right sample, two's complement.
- sample_valid  in  1  one-cycle strobe; connected to xxxx_zero.
- sample_ready  out  1  holding buffer empty.
- aud_bclk  out  1  bit clock.
- aud_lrck  out  1  word select; 0 = left, 1 = right.
- aud_dacdat  out  1  serial data.
- underrun  out  1  one-cycle pulse.
- overrun  out  1  one-cycle pulse.
- frame_start  out  1  one-cycle pulse when a frame is loaded.

Behaviour:
- Reset values: aud_bclk=0, aud_lrck=1, aud_dacdat=0, sample_ready=1, underrun=0, overrun=0, frame_start=0. Holding buffer, shift registers and last-sample registers are all zero. FSM state is IDLE.
- Divider:
  - div_cnt counts 0..BCLK_HALF-1 while state is not IDLE.
  - On wrap, aud_bclk toggles.
  - A 1->0 toggle is a "fall event"; bit_cnt (0..2*SLOT_W-1) advances on each fall event and wraps.
- Framing:
  - On the fall event that sets bit_cnt=0, aud_lrck goes 0; on the fall event that sets bit_cnt=SLOT_W, it goes 1.
  - All outputs change only on fall events; the codec samples on the BCLK rising edge.
- Data (Philips one-bit delay): at slot position p (0..SLOT_W-1):
  - p=0: aud_dacdat=0.
  - 1<=p<=SAMPLE_W: aud_dacdat = sample bit [SAMPLE_W-p].
  - p>SAMPLE_W: aud_dacdat = 0.
- Holding buffer:
  - sample_valid with buffer empty: capture both samples and set full; sample_ready falls the next cycle.
  - sample_valid with buffer full: overwrite with the new samples and pulse overrun.
- Frame load, at the fall event that sets bit_cnt=0:
  - Buffer full: copy buffer into the L/R shift registers and last-sample registers, clear full, pulse frame_start.
  - Buffer empty: reload the last-sample registers (repeat the previous sample), pulse underrun, pulse frame_start.
- Simultaneous sample_valid and frame load, buffer empty: sample_valid is applied first, and the new data is loaded directly into the frame with no underrun.
- Simultaneous sample_valid and frame load, buffer full: the old buffer is loaded into the frame and the new data is written to the buffer. No overrun is flagged.
- Latency: a sample accepted during frame N is transmitted in frame N+1. Its MSB appears on aud_dacdat at the second fall event of that frame.
- FSM:
  - IDLE: divider stopped, aud_bclk=0, aud_lrck=1. On enable=1 -> START.
  - START: a single cycle that clears div_cnt and sets bit_cnt=2*SLOT_W-1, so the first fall event is a frame load. -> RUN.
  - RUN: normal operation. On enable=0 -> DRAIN.
  - DRAIN: continue until the fall event that would set bit_cnt=0, without loading. Then -> IDLE with aud_dacdat=0. If enable returns high before that event, go back to RUN.
- Asynchronous reset mid-frame forces all outputs to their reset values immediately and discards buffered data.

Optional Feature:
- Macro I2S_MCLK_EN.
- When defined, adds output port aud_mclk (1 bit) = CLOCK_50 divided by 2*BCLK_HALF/4, generated only while not IDLE, giving MCLK = 4*BCLK. It is 0 in reset and IDLE. This requires BCLK_HALF to be a multiple of 4, checked by elaboration assertion.
- When undefined, there is no aud_mclk port and no extra logic; the codec supplies its own MCLK.

Decomposition:
- Package audio_pkg holds:
  - typedef i2s_state_t (IDLE, START, RUN, DRAIN);
  - constant default values for SAMPLE_W, SLOT_W and BCLK_HALF;
  - function frame_bits(SLOT_W)=2*SLOT_W.
- One sub-module, i2s_clkgen: divider, aud_bclk, aud_lrck, bit_cnt, fall-event strobe, and the optional MCLK.
- The serialiser, holding buffer and FSM stay in the top module.

Test Plan:
- Single sample: reset, enable=1, lsample=24'h800001, rsample=24'h7FFFFE with a valid strobe before the first load. aud_dacdat in the left slot is 0,1,0…0,1 followed by 7 zeros; in the right slot it is 0,0,1…1,0 followed by 7 zeros. aud_lrck period is 64 BCLKs and BCLK period is 16 CLOCK_50 cycles.
- Underrun: one valid strobe, then none for 2 frames. Two underrun pulses occur, and both frames repeat the same L/R data.
- Overrun: two valid strobes 10 cycles apart within one frame (values A then B). One overrun pulse occurs, and the next frame transmits B.
- Simultaneous strobe and load, buffer empty: the strobe lands on the load cycle. No underrun, the new data is in the same frame, and sample_ready stays 1.
- Disable mid-frame: deassert enable at bit_cnt=20. The frame completes to bit_cnt=63, then IDLE with aud_bclk=0, aud_lrck=1 and no frame_start. Re-enable restarts with a load on the first fall event.
- Reset mid-frame: assert reset_reg_n low at bit_cnt=40. Outputs reach their reset values in the same cycle, and after release with enable=1 the first frame produces an underrun carrying zero data.
